// File: rtl/fractcam_key_gen_if.sv
// Search-key handshake between the key generator and the TCAM search port.
// The generator drives key/sel/key_valid; the search port returns key_ready.
interface fractcam_key_gen_if #(
  parameter int KEY_SIZE = 40,
  parameter int SN       = 4
);
  logic [KEY_SIZE-1:0] key;
  logic [SN-1:0]       sel;
  logic                key_valid;
  logic                key_ready;

  modport master (output key, output sel, output key_valid, input key_ready);
  modport slave  (input key, input sel, input key_valid, output key_ready);
endinterface

// File: rtl/fractcam_key_gen.sv
// FRACTCAM search-key and sub-block-select generator.
// Emits num_keys keys over a valid/ready handshake using one of four key
// sequences (fixed, increment, LFSR, walking-one) and a fixed or
// round-robin select. All outputs come straight from registers.
module fractcam_key_gen #(
  parameter int                  KEY_SIZE  = 40,
  parameter int                  SN        = 4,
  parameter int                  CNT_W     = 16,
  parameter logic [KEY_SIZE-1:0] LFSR_TAPS = KEY_SIZE'(40'hA000140000)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                sel_mode,
  input  logic [KEY_SIZE-1:0] base_key,
  input  logic [SN-1:0]       sel_base,
  input  logic [CNT_W-1:0]    num_keys,
  fractcam_key_gen_if.master  kif,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    keys_sent
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q;
  logic [SN-1:0]       sel_q;
  logic [1:0]          mode_q;
  logic                sel_mode_q;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    sent_q;
  logic                hs;

  // First key of a run; the LFSR must never be seeded with all zeros.
  function automatic logic [KEY_SIZE-1:0] first_key(input logic [1:0]          m,
                                                     input logic [KEY_SIZE-1:0] b);
    case (m)
      2'd2:    first_key = (b == '0) ? KEY_SIZE'(1) : b;
      2'd3:    first_key = KEY_SIZE'(1);
      default: first_key = b;
    endcase
  endfunction

  // Key following k in the selected sequence.
  function automatic logic [KEY_SIZE-1:0] next_key(input logic [1:0]          m,
                                                    input logic [KEY_SIZE-1:0] k);
    case (m)
      2'd1:    next_key = k + KEY_SIZE'(1);
      2'd2:    next_key = {k[KEY_SIZE-2:0], ^(k & LFSR_TAPS)};
      2'd3:    next_key = {k[KEY_SIZE-2:0], k[KEY_SIZE-1]};
      default: next_key = k;
    endcase
  endfunction

  assign hs = (state_q == S_RUN) && kif.key_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a zero-length run goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (num_keys != '0) ? S_RUN : S_DONE;
      S_RUN:  if (hs && ((sent_q + CNT_W'(1)) == num_q)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Run configuration latch, key/select sequencing and handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q      <= '0;
      sel_q      <= '0;
      mode_q     <= '0;
      sel_mode_q <= 1'b0;
      num_q      <= '0;
      sent_q     <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      mode_q     <= mode;
      sel_mode_q <= sel_mode;
      num_q      <= num_keys;
      sent_q     <= '0;
      if (num_keys != '0) begin
        key_q <= first_key(mode, base_key);
        sel_q <= sel_base;
      end
    end else if (hs) begin
      sent_q <= sent_q + CNT_W'(1);
      key_q  <= next_key(mode_q, key_q);
      sel_q  <= sel_mode_q ? sel_q + SN'(1) : sel_q;
    end
  end

  assign kif.key       = key_q;
  assign kif.sel       = sel_q;
  assign kif.key_valid = (state_q == S_RUN);
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign keys_sent     = sent_q;

endmodule

// File: doc/fractcam_key_gen.md
# fractcam_key_gen

Parametrised search-key and sub-block-select generator for the FRACTCAM search path. It drives keys into the TCAM search port through a valid/ready handshake. It supports four key sequences (fixed, incrementing, LFSR pseudo-random, walking-one) and two select modes (fixed, round-robin), and runs for a programmable number of keys. It replaces the static all-zero key/select stub used for early bring-up, and serves as stimulus for throughput and match-rate measurement.

## Interface
- KEY_SIZE, 40, key width in bits
- SN, 4, sub-block select width
- CNT_W, 16, width of key-count and sent-count
- LFSR_TAPS, 40'hA000140000, feedback mask (bits 39, 37, 20, 18); width KEY_SIZE
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- mode  in  2  key sequence: 0 fixed, 1 increment, 2 LFSR, 3 walking-one; latched at start
- sel_mode  in  1  0 fixed select, 1 round-robin; latched at start
- base_key  in  KEY_SIZE  first key / LFSR seed; latched at start
- sel_base  in  SN  first select value; latched at start
- num_keys  in  CNT_W  keys to emit; latched at start
- key  out  KEY_SIZE  current search key
- sel  out  SN  current sub-block select
- key_valid  out  1  key/sel valid
- key_ready  in  1  downstream accepts key this cycle
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run
- keys_sent  out  CNT_W  handshakes completed in current/last run

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, num_keys≠0: latch the inputs, load the first key and select, clear keys_sent, go to RUN.
- IDLE, start=1, num_keys=0: go to DONE. No key is emitted and keys_sent is cleared to 0.
- RUN: key_valid=1. Each cycle with key_valid & key_ready is one handshake:
  - keys_sent increments.
  - Key and select advance.
  - On the handshake that makes keys_sent equal the latched num_keys, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. Input changes after start are ignored.
- First key by mode:
  - Mode 0 and mode 1: base_key.
  - Mode 2: base_key, or 1 if base_key=0 (the all-zero lock state is forbidden).
  - Mode 3: 1.
- Key advance by mode:
  - Mode 0: unchanged.
  - Mode 1: key+1, modulo 2^KEY_SIZE (all-ones wraps to 0).
  - Mode 2: {key[KEY_SIZE-2:0], ^(key & LFSR_TAPS)}.
  - Mode 3: rotate left by 1 (MSB wraps to bit 0).
- Select:
  - Starts at sel_base.
  - sel_mode=0: held.
  - sel_mode=1: sel+1 per handshake, modulo 2^SN.
- keys_sent holds its final value through IDLE until the next accepted start.

## Timing
- Reset values: key=0, sel=0, key_valid=0, busy=0, done=0, keys_sent=0, state IDLE.
- Reset asserted mid-run aborts immediately to these values. No done pulse is produced.
- Start accepted at edge N: key_valid=1 and busy=1 from cycle N+1, with the first key.
- Each handshake at edge M presents the next key at M+1. Throughput is 1 key/cycle with key_ready held high.
- key_valid=1 with key_ready=0: key and sel must stay stable. No advance, no count.
- Last handshake at edge M: key_valid=0, busy=0, done=1 in cycle M+1; done=0 at M+2.
- start held high continuously re-arms at the first IDLE cycle after DONE (one dead cycle between runs).
- All outputs are registered. No combinational path from key_ready to key_valid.

## Test plan
- Reset during RUN, mode 1, after 3 handshakes -> all outputs 0 next cycle. Release, then start num_keys=2 -> normal run, keys_sent=2, one done pulse.
- Mode 1, base_key=40'hFF_FFFF_FFFE, num_keys=4, sel_mode=1, sel_base=4'hE, key_ready=1 -> keys FFFFFFFFFE, FFFFFFFFFF, 0000000000, 0000000001. Sels E, F, 0, 1. done 1 cycle after 4th handshake, keys_sent=4.
- Mode 2, base_key=0, num_keys=3 -> keys 1, 2, 4. Mode 2, base_key=40'h80_0000_0000 -> second key 40'h00_0000_0001.
- Mode 3, num_keys=41, key_ready toggling 1/0 -> key 1 shifts through bit 39 then wraps back to 1 on the 41st. The key is stable during every ready-low cycle, and keys_sent=41.
- Mode 0, base_key=40'h12_3456_789A, sel_base=3, sel_mode=0, num_keys=5 -> key and sel constant for all 5 handshakes. A start pulse mid-run is ignored (no restart).
- num_keys=0 start -> key_valid never rises, done pulses at N+1, keys_sent=0.
